// File: rtl/umul_array.sv
// umul_array: NCH-channel stochastic multiplier.
// Each channel gates an in-block Sobol dim-1 sequence with its input bitstream and
// compares it against a buffered binary operand. Unipolar (AND) or bipolar (XNOR) mode.
// One-cycle registered output with valid and an end-of-stream pulse every 2**WIDTH samples.
module umul_array #(
  parameter int WIDTH   = 8,
  parameter int NCH     = 4,
  parameter int BIPOLAR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NCH-1:0]       in_a,
  input  logic [NCH*WIDTH-1:0] in_b,
  input  logic                 load_b,
  output logic [NCH-1:0]       out_c,
  output logic                 out_valid,
  output logic                 out_done
);

  // Sobol dim-1 value: bit-reversed Gray code of the counter.
  function automatic logic [WIDTH-1:0] sobol(input logic [WIDTH-1:0] cnt);
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] res;
    gray = cnt ^ (cnt >> 1);
    for (int k = 0; k < WIDTH; k++) begin
      res[k] = gray[WIDTH-1-k];
    end
    return res;
  endfunction

  logic [WIDTH-1:0] b_buf [NCH];
  logic [WIDTH-1:0] ca    [NCH];
  logic [WIDTH-1:0] cn    [NCH];
  logic [WIDTH-1:0] sc;

  logic             acc_p0;
  logic [NCH-1:0]   c_p0;

  logic [NCH-1:0]   c_p1;
  logic             vld_p1;
  logic             done_p1;

  // ---- stage p0: combinational product bit per channel (counters before increment)
  // Compare each operand against the Sobol value selected by the stream bit.
  always_comb begin
    acc_p0 = in_valid & ~load_b;
    c_p0   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (BIPOLAR != 0) begin
        c_p0[i] = in_a[i] ? (b_buf[i] > sobol(ca[i]))
                          : ~(b_buf[i] > sobol(cn[i]));
      end else begin
        c_p0[i] = in_a[i] & (b_buf[i] > sobol(ca[i]));
      end
    end
  end

  // ---- stage p1: registered outputs, operand buffer and stream/RNG counters
  // Reset beats load, load beats an incoming sample (which is dropped).
  always_ff @(posedge clk) begin
    if (rst) begin
      sc      <= '0;
      c_p1    <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        b_buf[i] <= '0;
        ca[i]    <= '0;
        cn[i]    <= '0;
      end
    end else if (load_b) begin
      sc      <= '0;
      c_p1    <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        b_buf[i] <= in_b[i*WIDTH +: WIDTH];
        ca[i]    <= '0;
        cn[i]    <= '0;
      end
    end else begin
      vld_p1  <= acc_p0;
      c_p1    <= acc_p0 ? c_p0 : '0;
      done_p1 <= acc_p0 && (sc == '1);
      if (acc_p0) begin
        // Stream counter wraps freely; RNGs never stall.
        sc <= sc + 1'b1;
        for (int i = 0; i < NCH; i++) begin
          if (in_a[i]) begin
            ca[i] <= ca[i] + 1'b1;
          end else begin
            cn[i] <= cn[i] + 1'b1;
          end
        end
      end
    end
  end

  assign out_c     = c_p1;
  assign out_valid = vld_p1;
  assign out_done  = done_p1;

endmodule

// File: tb/tb_umul_array.sv
// tb_umul_array: directed + randomized bench for umul_array (WIDTH=8, NCH=2).
// A unipolar and a bipolar instance share the same stimulus; a behavioural model
// predicts every output cycle, and stream-level ones/done counts are checked
// against the expected products.
module tb_umul_array;
  localparam int W = 8;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           load_b;
  logic [N-1:0]   in_a;
  logic [N*W-1:0] in_b;
  logic [N-1:0]   uc, bc;
  logic           uv, ud, bv, bd;

  always #5 clk = ~clk;

  umul_array #(.WIDTH(W), .NCH(N), .BIPOLAR(0)) u_uni (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .load_b(load_b), .out_c(uc), .out_valid(uv), .out_done(ud));

  umul_array #(.WIDTH(W), .NCH(N), .BIPOLAR(1)) u_bip (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .load_b(load_b), .out_c(bc), .out_valid(bv), .out_done(bd));

  int ntests = 0;
  int nfail  = 0;

  // behavioural model state
  int         m_b  [N];
  int         m_ca [N];
  int         m_cn [N];
  int         m_sc;
  logic [N-1:0] e_cu, e_cb;
  logic       e_v, e_d;

  // stream statistics
  int ones_u [N];
  int ones_b [N];
  int nvalid, ndone, done_at;

  // Sobol dim-1 point n of a 2**W-long sequence, as an integer.
  function automatic int sob(input int n);
    int g, r;
    g = n ^ (n >> 1);
    r = 0;
    for (int k = 0; k < W; k++) begin
      if ((g >> k) & 1) r = r + (1 << (W - 1 - k));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    for (int i = 0; i < N; i++) begin
      ones_u[i] = 0;
      ones_b[i] = 0;
    end
    nvalid  = 0;
    ndone   = 0;
    done_at = -1;
  endtask

  // One clock: drive inputs, advance the model, check all outputs 1ns after the edge.
  task automatic cyc(input logic r, input logic v, input logic ld, input logic [N-1:0] a);
    rst = r; in_valid = v; load_b = ld; in_a = a;
    if (r) begin
      for (int i = 0; i < N; i++) begin m_b[i] = 0; m_ca[i] = 0; m_cn[i] = 0; end
      m_sc = 0; e_v = 0; e_d = 0; e_cu = '0; e_cb = '0;
    end else if (ld) begin
      for (int i = 0; i < N; i++) begin
        m_b[i] = int'(in_b[i*W +: W]); m_ca[i] = 0; m_cn[i] = 0;
      end
      m_sc = 0; e_v = 0; e_d = 0; e_cu = '0; e_cb = '0;
    end else begin
      e_v = v;
      e_d = v && (m_sc == (1 << W) - 1);
      e_cu = '0; e_cb = '0;
      if (v) begin
        for (int i = 0; i < N; i++) begin
          if (a[i]) begin
            e_cu[i] = (m_b[i] > sob(m_ca[i]));
            e_cb[i] = (m_b[i] > sob(m_ca[i]));
            m_ca[i] = (m_ca[i] + 1) % (1 << W);
          end else begin
            e_cb[i] = !(m_b[i] > sob(m_cn[i]));
            m_cn[i] = (m_cn[i] + 1) % (1 << W);
          end
        end
        m_sc = (m_sc + 1) % (1 << W);
      end
    end
    @(posedge clk);
    #1;
    chk("uni_out_valid", int'(uv), int'(e_v));
    chk("uni_out_done",  int'(ud), int'(e_d));
    chk("uni_out_c",     int'(uc), int'(e_cu));
    chk("bip_out_valid", int'(bv), int'(e_v));
    chk("bip_out_done",  int'(bd), int'(e_d));
    chk("bip_out_c",     int'(bc), int'(e_cb));
    if (uv) begin
      nvalid++;
      for (int i = 0; i < N; i++) begin
        ones_u[i] += int'(uc[i]);
        ones_b[i] += int'(bc[i]);
      end
    end
    if (ud) begin
      ndone++;
      done_at = nvalid;
    end
  endtask

  int exp_seq [4] = '{1, 1, 0, 1};

  initial begin
    in_b = '0;
    clr_stats();

    // reset state
    cyc(1, 0, 0, 2'b00);
    cyc(1, 1, 0, 2'b11);
    chk("reset_out_c", int'({uc, bc}), 0);

    // full unipolar stream, B = 128 / 255
    in_b = {8'd255, 8'd128};
    cyc(0, 0, 1, 2'b00);
    clr_stats();
    repeat (256) cyc(0, 1, 0, 2'b11);
    chk("t1_ones_ch0", ones_u[0], 128);
    chk("t1_ones_ch1", ones_u[1], 255);
    chk("t1_bip_ones_ch0", ones_b[0], 128);
    chk("t1_done_count", ndone, 1);
    chk("t1_done_at", done_at, 256);

    // Sobol order with B = 129, then a held counter on a zero bit
    in_b = {8'd129, 8'd129};
    cyc(0, 0, 1, 2'b00);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 2'b11);
      chk("t2_sobol_order", int'(uc[0]), exp_seq[k]);
    end
    cyc(0, 1, 0, 2'b00);
    chk("t2_zero_bit", int'(uc[0]), 0);
    cyc(0, 1, 0, 2'b11);
    chk("t2_ca_held", int'(uc[0]), 1);

    // bipolar: B = 192 all ones, all zeros, B = 128 alternating
    in_b = {8'd192, 8'd192};
    cyc(0, 0, 1, 2'b00);
    clr_stats();
    repeat (256) cyc(0, 1, 0, 2'b11);
    chk("t3_bip_ones_a1", ones_b[0], 192);
    clr_stats();
    repeat (256) cyc(0, 1, 0, 2'b00);
    chk("t3_bip_ones_a0", ones_b[1], 64);
    chk("t3_uni_ones_a0", ones_u[0], 0);
    in_b = {8'd128, 8'd128};
    cyc(0, 0, 1, 2'b00);
    clr_stats();
    for (int k = 0; k < 256; k++) cyc(0, 1, 0, (k % 2 == 0) ? 2'b11 : 2'b00);
    chk("t3_bip_ones_alt", ones_b[0], 128);
    chk("t3_done_count", ndone, 1);

    // 50% in_valid over 512 cycles
    in_b = {8'd255, 8'd128};
    cyc(0, 0, 1, 2'b00);
    clr_stats();
    for (int k = 0; k < 512; k++) cyc(0, 1'($urandom_range(0, 1)), 0, 2'b11);
    chk("t4_done_vs_valid", ndone, nvalid / 256);

    // load at sample 100 drops that sample and restarts the stream
    in_b = {8'd255, 8'd128};
    cyc(0, 0, 1, 2'b00);
    repeat (99) cyc(0, 1, 0, 2'b11);
    cyc(0, 1, 1, 2'b11);
    chk("t5_valid_after_load", int'(uv), 0);
    clr_stats();
    repeat (255) cyc(0, 1, 0, 2'b11);
    chk("t5_no_early_done", ndone, 0);
    cyc(0, 1, 0, 2'b11);
    chk("t5_done_count", ndone, 1);
    chk("t5_done_at", done_at, 256);
    chk("t5_ones_ch0", ones_u[0], 128);

    // reset with load mid-stream clears the operand
    repeat (20) cyc(0, 1, 0, 2'b11);
    in_b = {8'd200, 8'd77};
    cyc(1, 1, 1, 2'b11);
    chk("t6_outputs_zero", int'({uc, uv, ud, bc, bv, bd}), 0);
    clr_stats();
    repeat (10) cyc(0, 1, 0, 2'b11);
    chk("t6_ones_after_rst", ones_u[0] + ones_u[1] + ones_b[0] + ones_b[1], 0);

    // randomized traffic with occasional loads and resets
    for (int k = 0; k < 800; k++) begin
      logic r, ld;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 39) == 0);
      if (ld) in_b = N*W'($urandom);
      cyc(r, 1'($urandom_range(0, 1)), ld, N'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
